// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// LSB-first over WIDTH cycles, registered sum/cout/ovf with a done pulse.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             c;
  logic             cm;
  logic [CW-1:0]    cnt;

  logic s;
  logic cn;
  logic last;
  logic cmsb;

  always_comb begin
    s    = ra[0] ^ rb[0] ^ c;
    cn   = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    last = (cnt == CW'(WIDTH - 1));
    // on the last bit the carry into the MSB is the live carry flop
    cmsb = last ? c : cm;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      rs   <= '0;
      c    <= 1'b0;
      cm   <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= sub ? ~b : b;
            c   <= sub;
            cnt <= '0;
          end
        end
        RUN: begin
          c   <= cn;
          rs  <= {s, rs[WIDTH-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          cnt <= cnt + CW'(1);
          if (last) begin
            cm   <= c;
            sum  <= {s, rs[WIDTH-1:1]};
            cout <= cn;
            ovf  <= cn ^ cmsb;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: expected results queued at accept,
// compared (with latency) when done pulses.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  serial_addsub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   pushes   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic ts);
    logic [W:0] full;
    exp_t e;
    if (ts) full = {1'b0, ta} + {1'b0, ~tb_} + (W+1)'(1);
    else    full = {1'b0, ta} + {1'b0, tb_};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    if (ts) e.ovf = (ta[W-1] != tb_[W-1]) && (e.sum[W-1] != ta[W-1]);
    else    e.ovf = (ta[W-1] == tb_[W-1]) && (e.sum[W-1] != ta[W-1]);
    e.acc = cyc + 1;
    q.push_back(e);
    pushes++;
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("latency", 32'(cyc - e.acc), 32'(W));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    sub   = ts;
    push_exp(ta, tb_, ts);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
    chk("busy_run", 32'(busy), 32'(1));
    chk("done_early", 32'(done), 32'(0));
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("timeout", 32'(q.size()), 32'(0));
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'(0));
    chk("done_clear", 32'(done), 32'(0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));

    run_op(8'h35, 8'h4A, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h05, 8'h07, 1'b1);
    run_op(8'h80, 8'h01, 1'b1);

    // starts during RUN and DONE must be dropped
    @(negedge clk);
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    sub   = 1'b0;
    push_exp(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("done_cycle", 32'(done), 32'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'(0));
    repeat (12) @(negedge clk);
    chk("ign_queue", 32'(q.size()), 32'(0));
    chk("ign_count", 32'(done_cnt), 32'(pushes));

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_done", 32'(done), 32'(0));
    chk("mr_sum", 32'(sum), 32'(0));
    chk("mr_cout", 32'(cout), 32'(0));
    chk("mr_ovf", 32'(ovf), 32'(0));
    repeat (12) @(negedge clk);
    chk("mr_count", 32'(done_cnt), 32'(pushes));
    run_op(8'h01, 8'h02, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    repeat (12) @(negedge clk);
    chk("final_count", 32'(done_cnt), 32'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
